// File: rtl/gat_run_ctrl.sv
// Run sequencer for gat_top: waits for BRAM loads, launches each layer on the core,
// watches gat_ready for completion or timeout, and reports done/err plus debug status.
module gat_run_ctrl #(
    parameter int unsigned TOP_WIDTH      = 32,
    parameter int unsigned NUM_LAYERS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16777216,
    parameter int unsigned TMO_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 h_data_done,
    input  logic                 h_node_done,
    input  logic                 wgt_done,
    input  logic                 gat_ready,
    output logic                 gat_layer,
    output logic                 core_start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [TOP_WIDTH-1:0] status,
    output logic [TOP_WIDTH-1:0] run_cycles
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLoad = 3'd1,
        StLaunch   = 3'd2,
        StRun      = 3'd3,
        StNext     = 3'd4,
        StDone     = 3'd5,
        StErr      = 3'd6
    } state_t;

    state_t           state;
    logic             layer_idx;
    logic             seen_h;
    logic             seen_node;
    logic             seen_wgt;
    logic             seen_busy;
    logic             h_data_q;
    logic             h_node_q;
    logic             wgt_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic h_rise;
    logic node_rise;
    logic wgt_rise;
    logic loads_ok;
    logic run_done;
    logic tmo_hit;
    logic in_busy;
    logic start_ok;
    logic abort_run;

    // Edge detection, launch/complete/timeout conditions decoded from current state.
    always_comb begin
        h_rise    = h_data_done & ~h_data_q;
        node_rise = h_node_done & ~h_node_q;
        wgt_rise  = wgt_done & ~wgt_q;
        loads_ok  = (layer_idx == 1'b0) ? (seen_h & seen_node & seen_wgt) : seen_wgt;
        // seen_busy is registered, so a ready still high from the last layer cannot complete
        run_done  = seen_busy & gat_ready;
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        in_busy   = (state == StWaitLoad) || (state == StLaunch) ||
                    (state == StRun) || (state == StNext);
        start_ok  = start & ~abort & ((state == StIdle) || (state == StErr));
        abort_run = abort & (state != StIdle);
    end

    // Debug status word assembled from the state registers.
    always_comb begin
        status = {{(TOP_WIDTH-7){1'b0}}, seen_wgt, seen_node, seen_h, layer_idx, state};
    end

    // Sequencer FSM, load tracking, counters and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            layer_idx  <= 1'b0;
            seen_h     <= 1'b0;
            seen_node  <= 1'b0;
            seen_wgt   <= 1'b0;
            seen_busy  <= 1'b0;
            h_data_q   <= 1'b0;
            h_node_q   <= 1'b0;
            wgt_q      <= 1'b0;
            tmo_cnt    <= '0;
            run_cycles <= '0;
            gat_layer  <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            h_data_q <= h_data_done;
            h_node_q <= h_node_done;
            wgt_q    <= wgt_done;

            if (abort) begin
                seen_h    <= 1'b0;
                seen_node <= 1'b0;
                seen_wgt  <= 1'b0;
            end else begin
                seen_h    <= seen_h | h_rise;
                seen_node <= seen_node | node_rise;
                // Next layer needs a fresh weight load; a load landing right now still counts
                if (state == StNext) begin
                    seen_wgt <= wgt_rise;
                end else begin
                    seen_wgt <= seen_wgt | wgt_rise;
                end
            end

            if (start_ok) begin
                run_cycles <= '0;
            end else if (in_busy && (run_cycles != '1)) begin
                run_cycles <= run_cycles + 1'b1;
            end

            // Outputs are a registered decode of the current state
            core_start <= (state == StLaunch);
            busy       <= in_busy;
            done       <= (state == StDone);
            err        <= (state == StErr) & ~start_ok;
            if (state == StLaunch) begin
                gat_layer <= layer_idx;
            end

            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        layer_idx <= 1'b0;
                        state     <= StWaitLoad;
                    end
                end
                StWaitLoad: begin
                    if (loads_ok) begin
                        state <= StLaunch;
                    end
                end
                StLaunch: begin
                    seen_busy <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= StRun;
                end
                StRun: begin
                    if (!gat_ready) begin
                        seen_busy <= 1'b1;
                    end
                    if (run_done) begin
                        state <= StNext;
                    end else if (tmo_hit) begin
                        state <= StErr;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StNext: begin
                    if (layer_idx == 1'(NUM_LAYERS - 1)) begin
                        state <= StDone;
                    end else begin
                        layer_idx <= layer_idx + 1'b1;
                        state     <= StWaitLoad;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                StErr: begin
                    if (start_ok) begin
                        layer_idx <= 1'b0;
                        state     <= StWaitLoad;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            // Abort overrides everything except reset
            if (abort_run) begin
                state      <= StIdle;
                core_start <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
                err        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gat_run_ctrl.sv
// Directed bench for gat_run_ctrl with a 100-cycle timeout; expected values hand-computed.
module tb_gat_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        h_data_done;
    logic        h_node_done;
    logic        wgt_done;
    logic        gat_ready;
    logic        gat_layer;
    logic        core_start;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] status;
    logic [31:0] run_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    gat_run_ctrl #(
        .TOP_WIDTH      (32),
        .NUM_LAYERS     (2),
        .TIMEOUT_CYCLES (100),
        .TMO_W          (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .h_data_done (h_data_done),
        .h_node_done (h_node_done),
        .wgt_done    (wgt_done),
        .gat_ready   (gat_ready),
        .gat_layer   (gat_layer),
        .core_start  (core_start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .status      (status),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        h_data_done = 1'b0; h_node_done = 1'b0; wgt_done = 1'b0; gat_ready = 1'b1;
        tick(2);
        chk("rst_status", status, 32'h0);
        chk("rst_cycles", run_cycles, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_err", err, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_cstart", core_start, 32'h0);
        rst = 1'b0;
        tick(1);

        // Two-layer run, all loads before start
        h_data_done = 1'b1; h_node_done = 1'b1; wgt_done = 1'b1;
        tick(1);
        chk("t1_seen", status, 32'h70);
        h_data_done = 1'b0; h_node_done = 1'b0; wgt_done = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t1_wait", status, 32'h71);
        chk("t1_busy_lag", busy, 32'h0);
        tick(1);
        chk("t1_launch", status, 32'h72);
        chk("t1_busy", busy, 32'h1);
        chk("t1_cstart_early", core_start, 32'h0);
        chk("t1_cycles1", run_cycles, 32'h1);
        tick(1);
        chk("t1_cstart0", core_start, 32'h1);
        chk("t1_layer0", gat_layer, 32'h0);
        chk("t1_run", status, 32'h73);
        tick(1);
        chk("t1_cstart_pulse", core_start, 32'h0);
        chk("t1_stale_ready", status, 32'h73);
        gat_ready = 1'b0;
        tick(50);
        chk("t1_run_hold", status, 32'h73);
        gat_ready = 1'b1;
        tick(1);
        chk("t1_next0", status, 32'h74);
        tick(1);
        chk("t1_wait1", status, 32'h39);
        tick(2);
        chk("t1_wait1_hold", status, 32'h39);
        chk("t1_no_cstart", core_start, 32'h0);
        wgt_done = 1'b1;
        tick(1);
        chk("t1_wgt1", status, 32'h79);
        wgt_done = 1'b0;
        tick(1);
        chk("t1_launch1", status, 32'h7A);
        tick(1);
        chk("t1_cstart1", core_start, 32'h1);
        chk("t1_layer1", gat_layer, 32'h1);
        chk("t1_run1", status, 32'h7B);
        gat_ready = 1'b0;
        tick(50);
        gat_ready = 1'b1;
        tick(1);
        chk("t1_next1", status, 32'h7C);
        tick(1);
        chk("t1_done_state", status, 32'h3D);
        chk("t1_done_lag", done, 32'h0);
        tick(1);
        chk("t1_done", done, 32'h1);
        chk("t1_busy_off", busy, 32'h0);
        chk("t1_layer_hold", gat_layer, 32'h1);
        chk("t1_idle", status, 32'h38);
        chk("t1_cycles", run_cycles, 32'd112);
        tick(1);
        chk("t1_done_pulse", done, 32'h0);
        chk("t1_cycles_frz", run_cycles, 32'd112);

        // Weight load arrives late
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t2_wait", status, 32'h31);
        tick(20);
        chk("t2_wait_hold", status, 32'h31);
        chk("t2_no_cstart", core_start, 32'h0);
        chk("t2_busy", busy, 32'h1);
        wgt_done = 1'b1;
        tick(1);
        chk("t2_wgt", status, 32'h71);
        wgt_done = 1'b0;
        tick(1);
        chk("t2_launch", status, 32'h72);
        chk("t2_cstart_early", core_start, 32'h0);
        tick(1);
        chk("t2_cstart", core_start, 32'h1);
        chk("t2_layer", gat_layer, 32'h0);
        chk("t2_cycles", run_cycles, 32'd23);

        // Core never completes: timeout after 100 RUN cycles
        gat_ready = 1'b0;
        tick(99);
        chk("t3_run", status, 32'h73);
        chk("t3_err_early", err, 32'h0);
        tick(1);
        chk("t3_err_state", status, 32'h76);
        tick(1);
        chk("t3_err", err, 32'h1);
        chk("t3_busy", busy, 32'h0);
        chk("t3_done", done, 32'h0);
        chk("t3_cycles", run_cycles, 32'd123);
        tick(3);
        chk("t3_err_sticky", err, 32'h1);
        chk("t3_state_hold", status[2:0], 32'h6);
        chk("t3_cycles_frz", run_cycles, 32'd123);

        // Restart from ERR, abort during layer 1
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t4_restart", status, 32'h71);
        chk("t4_err_clr", err, 32'h0);
        tick(2);
        chk("t4_cstart0", core_start, 32'h1);
        tick(1);
        gat_ready = 1'b1;
        tick(1);
        chk("t4_next0", status, 32'h74);
        tick(1);
        chk("t4_wait1", status, 32'h39);
        wgt_done = 1'b1;
        tick(1);
        wgt_done = 1'b0;
        tick(2);
        chk("t4_run1", status, 32'h7B);
        chk("t4_layer1", gat_layer, 32'h1);
        gat_ready = 1'b0;
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4_idle", status[2:0], 32'h0);
        chk("t4_flags", status[6:4], 32'h0);
        chk("t4_busy", busy, 32'h0);
        chk("t4_err", err, 32'h0);
        chk("t4_cstart", core_start, 32'h0);
        tick(3);
        chk("t4_no_done", done, 32'h0);

        // Ready stuck high gives no completion; late completion beats timeout
        gat_ready = 1'b1;
        h_data_done = 1'b1; h_node_done = 1'b1; wgt_done = 1'b1;
        tick(1);
        h_data_done = 1'b0; h_node_done = 1'b0; wgt_done = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("t5_cstart", core_start, 32'h1);
        tick(98);
        chk("t5_no_complete", status, 32'h73);
        gat_ready = 1'b0;
        tick(1);
        gat_ready = 1'b1;
        tick(1);
        chk("t5_next", status[2:0], 32'h4);
        tick(1);
        chk("t5_wait1", status[3:0], 32'h9);
        chk("t5_no_err", err, 32'h0);

        // start while busy ignored; reset mid-RUN; start+abort in IDLE
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t6_start_ign", status[3:0], 32'h9);
        wgt_done = 1'b1;
        tick(1);
        wgt_done = 1'b0;
        tick(2);
        chk("t6_run", status[2:0], 32'h3);
        gat_ready = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rst_status", status, 32'h0);
        chk("t6_rst_cycles", run_cycles, 32'h0);
        chk("t6_rst_busy", busy, 32'h0);
        chk("t6_rst_layer", gat_layer, 32'h0);
        chk("t6_rst_cstart", core_start, 32'h0);
        chk("t6_rst_err", err, 32'h0);
        chk("t6_rst_done", done, 32'h0);
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        chk("t6_sa_idle", status, 32'h0);
        tick(1);
        chk("t6_sa_busy", busy, 32'h0);
        chk("t6_sa_hold", status, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
